// File: rtl/eth_rx_dispatch_pkg.sv
// Shared constants, header field offsets and FSM state type for the Ethernet RX dispatcher.
// Frames carry 6 pad bytes, so the Ethernet, IPv4 and UDP headers fill exactly words 0..5.
package eth_rx_dispatch_pkg;

    localparam int unsigned HDR_WORDS = 6;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_VIHL        = 8'h45;
    localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

    // Word index and LSB of each field inside the header buffer.
    localparam int unsigned MAC_HI_WORD   = 0;
    localparam int unsigned MAC_HI_LSB    = 0;
    localparam int unsigned MAC_LO_WORD   = 1;
    localparam int unsigned MAC_LO_LSB    = 32;
    localparam int unsigned ETYPE_WORD    = 2;
    localparam int unsigned ETYPE_LSB     = 32;
    localparam int unsigned VIHL_WORD     = 2;
    localparam int unsigned VIHL_LSB      = 24;
    localparam int unsigned PROTO_WORD    = 3;
    localparam int unsigned PROTO_LSB     = 16;
    localparam int unsigned DIP_WORD      = 4;
    localparam int unsigned DIP_LSB       = 0;
    localparam int unsigned UDP_DPORT_WORD = 5;
    localparam int unsigned UDP_DPORT_LSB = 32;

    typedef enum logic [2:0] {
        StHdr,
        StDecide,
        StReplayCpu,
        StStreamCpu,
        StStreamChdr,
        StDrop
    } state_e;

    // 16-bit one's-complement addition with end-around carry.
    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'b0, s[16]};
    endfunction

endpackage

// File: rtl/eth_hdr_ipcsum.sv
// Streaming IPv4 header checksum: folds w2[31:0], w3 and w4 into a 16-bit one's-complement
// sum as the header words are accepted, so the result is ready in the decision cycle.
module eth_hdr_ipcsum
    import eth_rx_dispatch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        beat_i,
    input  logic [2:0]  idx_i,
    input  logic [63:0] data_i,
    output logic [15:0] sum_o
);

    logic [15:0] sum_q, sum_d;
    logic [15:0] quad_sum;

    always_comb begin
        quad_sum = ones_add16(ones_add16(sum_q, data_i[63:48]), data_i[47:32]);
        quad_sum = ones_add16(ones_add16(quad_sum, data_i[31:16]), data_i[15:0]);
    end

    always_comb begin
        sum_d = sum_q;
        if (beat_i) begin
            case (idx_i)
                3'd0:       sum_d = '0;
                3'd2:       sum_d = ones_add16(ones_add16(sum_q, data_i[31:16]), data_i[15:0]);
                3'd3, 3'd4: sum_d = quad_sum;
                default:    sum_d = sum_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/eth_rx_dispatch.sv
// Ethernet RX dispatcher: strips CHDR/UDP headers to the crossbar, replays other local or
// broadcast frames to the CPU, drops the rest. Optional IP checksum: ETH_RX_DISPATCH_IPCSUM_EN.
module eth_rx_dispatch
    import eth_rx_dispatch_pkg::*;
#(
    parameter int unsigned DROP_CNT_W = 32
) (
    input  logic                  bus_clk,
    input  logic                  bus_rst_n,
    input  logic [47:0]           my_mac,
    input  logic [31:0]           my_ip,
    input  logic [15:0]           my_udp_port,
    input  logic [63:0]           s_axis_tdata,
    input  logic [3:0]            s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [63:0]           chdr_tdata,
    output logic [3:0]            chdr_tuser,
    output logic                  chdr_tlast,
    output logic                  chdr_tvalid,
    input  logic                  chdr_tready,
    output logic [63:0]           cpu_tdata,
    output logic [3:0]            cpu_tuser,
    output logic                  cpu_tlast,
    output logic                  cpu_tvalid,
    input  logic                  cpu_tready,
    output logic [DROP_CNT_W-1:0] drop_count
);

    state_e                  state_q, state_d;
    logic [2:0]              hdr_cnt_q, hdr_cnt_d;
    logic [2:0]              rep_cnt_q, rep_cnt_d;
    logic [2:0]              len_q, len_d;
    logic                    short_q, short_d;
    logic                    ended_q, ended_d;
    logic [3:0]              last_user_q, last_user_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;
    logic [63:0]             hdr_q [HDR_WORDS];

    logic                    hdr_wr;
    logic [47:0]             dst_mac;
    logic                    mac_hit, bcast, csum_ok, is_chdr;
    logic                    rep_last;

    assign hdr_wr = (state_q == StHdr) && s_axis_tvalid && bus_rst_n;

    // Header buffer is pure data; only the control path needs a reset.
    always_ff @(posedge bus_clk) begin
        if (hdr_wr) begin
            hdr_q[hdr_cnt_q] <= s_axis_tdata;
        end
    end

`ifdef ETH_RX_DISPATCH_IPCSUM_EN
    logic [15:0] ip_sum;

    eth_hdr_ipcsum u_ipcsum (
        .clk_i  (bus_clk),
        .rst_ni (bus_rst_n),
        .beat_i (hdr_wr),
        .idx_i  (hdr_cnt_q),
        .data_i (s_axis_tdata),
        .sum_o  (ip_sum)
    );

    assign csum_ok = (ip_sum == 16'hFFFF);
`else
    assign csum_ok = 1'b1;
`endif

    assign dst_mac = {hdr_q[MAC_HI_WORD][MAC_HI_LSB +: 16], hdr_q[MAC_LO_WORD][MAC_LO_LSB +: 32]};
    assign mac_hit = (dst_mac == my_mac);
    assign bcast   = (dst_mac == BCAST_MAC);
    assign is_chdr = !short_q && mac_hit && csum_ok
                   && (hdr_q[ETYPE_WORD][ETYPE_LSB +: 16]         == ETHERTYPE_IPV4)
                   && (hdr_q[VIHL_WORD][VIHL_LSB +: 8]            == IP_VIHL)
                   && (hdr_q[PROTO_WORD][PROTO_LSB +: 8]          == IP_PROTO_UDP)
                   && (hdr_q[DIP_WORD][DIP_LSB +: 32]             == my_ip)
                   && (hdr_q[UDP_DPORT_WORD][UDP_DPORT_LSB +: 16] == my_udp_port);

    assign rep_last = (rep_cnt_q == len_q - 3'd1);

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_q     <= StHdr;
            hdr_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            len_q       <= '0;
            short_q     <= 1'b0;
            ended_q     <= 1'b0;
            last_user_q <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            len_q       <= len_d;
            short_q     <= short_d;
            ended_q     <= ended_d;
            last_user_q <= last_user_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        len_d       = len_q;
        short_d     = short_q;
        ended_d     = ended_q;
        last_user_d = last_user_q;
        drop_d      = drop_q;

        case (state_q)
            StHdr: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        state_d     = StDecide;
                        ended_d     = 1'b1;
                        short_d     = (hdr_cnt_q != 3'(HDR_WORDS - 1));
                        len_d       = hdr_cnt_q + 3'd1;
                        last_user_d = s_axis_tuser;
                        hdr_cnt_d   = '0;
                    end else if (hdr_cnt_q == 3'(HDR_WORDS - 1)) begin
                        state_d   = StDecide;
                        ended_d   = 1'b0;
                        short_d   = 1'b0;
                        len_d     = 3'(HDR_WORDS);
                        hdr_cnt_d = '0;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                    end
                end
            end
            StDecide: begin
                rep_cnt_d = '0;
                if (is_chdr) begin
                    // A CHDR header with nothing behind it has no payload to forward.
                    if (ended_q) begin
                        drop_d  = drop_q + 1'b1;
                        state_d = StHdr;
                    end else begin
                        state_d = StStreamChdr;
                    end
                end else if (mac_hit || bcast) begin
                    state_d = StReplayCpu;
                end else begin
                    drop_d  = drop_q + 1'b1;
                    state_d = ended_q ? StHdr : StDrop;
                end
            end
            StReplayCpu: begin
                if (cpu_tready) begin
                    if (rep_last) begin
                        state_d = ended_q ? StHdr : StStreamCpu;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 3'd1;
                    end
                end
            end
            StStreamCpu: begin
                if (s_axis_tvalid && cpu_tready && s_axis_tlast) begin
                    state_d = StHdr;
                end
            end
            StStreamChdr: begin
                if (s_axis_tvalid && chdr_tready && s_axis_tlast) begin
                    state_d = StHdr;
                end
            end
            StDrop: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = StHdr;
                end
            end
            default: state_d = StHdr;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        chdr_tdata    = '0;
        chdr_tuser    = '0;
        chdr_tlast    = 1'b0;
        chdr_tvalid   = 1'b0;
        cpu_tdata     = '0;
        cpu_tuser     = '0;
        cpu_tlast     = 1'b0;
        cpu_tvalid    = 1'b0;

        case (state_q)
            StHdr, StDrop: s_axis_tready = 1'b1;
            StReplayCpu: begin
                cpu_tvalid = 1'b1;
                cpu_tdata  = hdr_q[rep_cnt_q];
                // Only a frame that ended inside the header closes during replay.
                if (ended_q && rep_last) begin
                    cpu_tlast = 1'b1;
                    cpu_tuser = last_user_q;
                end
            end
            StStreamCpu: begin
                cpu_tvalid    = s_axis_tvalid;
                cpu_tdata     = s_axis_tdata;
                cpu_tuser     = s_axis_tuser;
                cpu_tlast     = s_axis_tlast;
                s_axis_tready = cpu_tready;
            end
            StStreamChdr: begin
                chdr_tvalid   = s_axis_tvalid;
                chdr_tdata    = s_axis_tdata;
                chdr_tuser    = s_axis_tuser;
                chdr_tlast    = s_axis_tlast;
                s_axis_tready = chdr_tready;
            end
            default: ;
        endcase

        if (!bus_rst_n) begin
            s_axis_tready = 1'b0;
        end
    end

    assign drop_count = drop_q;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Directed and randomised bench for eth_rx_dispatch; frames are built byte-wise and routed by
// an independent byte-level model feeding per-port scoreboards.
module tb_eth_rx_dispatch;

    localparam logic [47:0] MY_MAC  = 48'h00_80_2F_00_00_01;
    localparam logic [31:0] MY_IP   = {8'd192, 8'd168, 8'd10, 8'd2};
    localparam logic [15:0] MY_PORT = 16'd49153;

    logic        bus_clk = 1'b0;
    logic        bus_rst_n = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tuser = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] chdr_tdata, cpu_tdata;
    logic [3:0]  chdr_tuser, cpu_tuser;
    logic        chdr_tlast, chdr_tvalid, cpu_tlast, cpu_tvalid;
    logic        chdr_tready = 1'b1;
    logic        cpu_tready = 1'b1;
    logic [31:0] drop_count;

    eth_rx_dispatch #(.DROP_CNT_W(32)) dut (
        .bus_clk       (bus_clk),
        .bus_rst_n     (bus_rst_n),
        .my_mac        (MY_MAC),
        .my_ip         (MY_IP),
        .my_udp_port   (MY_PORT),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .chdr_tdata    (chdr_tdata),
        .chdr_tuser    (chdr_tuser),
        .chdr_tlast    (chdr_tlast),
        .chdr_tvalid   (chdr_tvalid),
        .chdr_tready   (chdr_tready),
        .cpu_tdata     (cpu_tdata),
        .cpu_tuser     (cpu_tuser),
        .cpu_tlast     (cpu_tlast),
        .cpu_tvalid    (cpu_tvalid),
        .cpu_tready    (cpu_tready),
        .drop_count    (drop_count)
    );

    always #5 bus_clk = ~bus_clk;

    typedef struct packed {
        logic        last;
        logic [3:0]  user;
        logic [63:0] data;
    } beat_t;

    typedef enum int {KChdr, KBcast, KMyOther, KForeign} kind_e;

    beat_t       exp_chdr[$];
    beat_t       exp_cpu[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_chdr_words = 0;
    int          n_cpu_words = 0;
    logic [31:0] exp_drops = '0;
    logic [7:0]  fb [256];
    int          f_nw;
    logic [3:0]  f_user;
    bit          rand_rdy = 1'b0;
    bit          rand_gap = 1'b0;

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fword(input int k);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[63-8*b -: 8] = fb[8*k+b];
        return w;
    endfunction

    task automatic build_frame(input kind_e k, input int nw, input logic [3:0] user,
                               input bit bad_csum);
        logic [47:0] dmac;
        logic [15:0] etype;
        logic [31:0] s;
        logic [15:0] c;
        for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) fb[i] = 8'h00;
        case (k)
            KBcast:   dmac = 48'hFFFF_FFFF_FFFF;
            KForeign: dmac = {8'h02, 40'($urandom)};
            default:  dmac = MY_MAC;
        endcase
        case (k)
            KBcast:   etype = 16'h0806;
            KMyOther: etype = 16'h86DD;
            default:  etype = 16'h0800;
        endcase
        for (int b = 0; b < 6; b++) fb[6+b] = dmac[47-8*b -: 8];
        fb[18] = etype[15:8];
        fb[19] = etype[7:0];
        if (etype == 16'h0800) begin
            fb[20] = 8'h45;
            fb[29] = 8'h11;
            for (int b = 0; b < 4; b++) fb[36+b] = MY_IP[31-8*b -: 8];
            fb[42] = MY_PORT[15:8];
            fb[43] = MY_PORT[7:0];
            fb[30] = 8'h00;
            fb[31] = 8'h00;
            s = 0;
            for (int j = 0; j < 10; j++) s = s + {16'h0, fb[20+2*j], fb[21+2*j]};
            s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
            s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
            c = ~s[15:0];
            if (bad_csum) c = c + 16'd1;
            fb[30] = c[15:8];
            fb[31] = c[7:0];
        end
        f_nw   = nw;
        f_user = user;
    endtask

    // Byte-level routing model of the current frame; pushes expected beats or counts a drop.
    task automatic expect_frame();
        logic [47:0] dmac;
        logic [31:0] dip;
        logic [31:0] s;
        bit          hit, bc, chdr, csum_good;
        beat_t       e;
        for (int b = 0; b < 6; b++) dmac[47-8*b -: 8] = fb[6+b];
        for (int b = 0; b < 4; b++) dip[31-8*b -: 8] = fb[36+b];
        s = 0;
        for (int j = 0; j < 10; j++) s = s + {16'h0, fb[20+2*j], fb[21+2*j]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        csum_good = (s[15:0] == 16'hFFFF);
        hit  = (dmac == MY_MAC);
        bc   = (dmac == 48'hFFFF_FFFF_FFFF);
        chdr = (f_nw >= 6) && hit && ({fb[18], fb[19]} == 16'h0800) && (fb[20] == 8'h45)
            && (fb[29] == 8'h11) && (dip == MY_IP) && ({fb[42], fb[43]} == MY_PORT);
`ifdef ETH_RX_DISPATCH_IPCSUM_EN
        chdr = chdr && csum_good;
`else
        if (!csum_good) chdr = chdr && 1'b1;
`endif
        if (chdr && f_nw > 6) begin
            for (int i = 6; i < f_nw; i++) begin
                e.data = fword(i);
                e.last = (i == f_nw - 1);
                e.user = e.last ? f_user : 4'h0;
                exp_chdr.push_back(e);
            end
        end else if (!chdr && (hit || bc)) begin
            for (int i = 0; i < f_nw; i++) begin
                e.data = fword(i);
                e.last = (i == f_nw - 1);
                e.user = e.last ? f_user : 4'h0;
                exp_cpu.push_back(e);
            end
        end else begin
            exp_drops = exp_drops + 32'd1;
        end
    endtask

    // Drives words 0..stop_at-1 of the current frame; returns at posedge+1 after the last accept.
    task automatic drive_frame(input int stop_at);
        bit acc;
        int t;
        for (int i = 0; i < stop_at; i++) begin
            if (rand_gap) begin
                while ($urandom_range(0, 2) == 0) begin
                    s_axis_tvalid = 1'b0;
                    @(posedge bus_clk);
                    #1;
                end
            end
            s_axis_tdata  = fword(i);
            s_axis_tlast  = (i == f_nw - 1);
            s_axis_tuser  = (i == f_nw - 1) ? f_user : 4'h0;
            s_axis_tvalid = 1'b1;
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 2000) begin
                @(negedge bus_clk);
                acc = s_axis_tready;
                @(posedge bus_clk);
                #1;
                t++;
            end
            if (!acc) begin
                check_val("s_accept_timeout", 72'd0, 72'd1);
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic run_frame(input kind_e k, input int nw, input logic [3:0] user,
                             input bit bad_csum);
        build_frame(k, nw, user, bad_csum);
        expect_frame();
        drive_frame(nw);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 1000 && (exp_chdr.size() + exp_cpu.size()) != 0; t++) begin
            @(posedge bus_clk);
        end
        repeat (4) @(posedge bus_clk);
        #1;
        check_val("drain_left", 72'(exp_chdr.size() + exp_cpu.size()), 72'd0);
    endtask

    task automatic clear_counts();
        n_chdr_words = 0;
        n_cpu_words  = 0;
    endtask

    always @(posedge bus_clk) begin
        #1;
        if (rand_rdy) begin
            chdr_tready = ($urandom_range(0, 3) != 0);
            cpu_tready  = ($urandom_range(0, 3) != 0);
        end else begin
            chdr_tready = 1'b1;
            cpu_tready  = 1'b1;
        end
    end

    logic  pc_v = 1'b0, pc_r = 1'b0, pu_v = 1'b0, pu_r = 1'b0;
    beat_t pc_b, pu_b;
    beat_t mon_e;

    always @(negedge bus_clk) begin
        if (!bus_rst_n) begin
            pc_v = 1'b0;
            pu_v = 1'b0;
        end else begin
            if (chdr_tvalid || cpu_tvalid)
                check_val("one_output", {71'b0, chdr_tvalid & cpu_tvalid}, 72'd0);
            if (pc_v && !pc_r)
                check_val("chdr_hold", {2'b0, chdr_tvalid, chdr_tlast, chdr_tuser, chdr_tdata},
                          {2'b0, 1'b1, pc_b});
            if (pu_v && !pu_r)
                check_val("cpu_hold", {2'b0, cpu_tvalid, cpu_tlast, cpu_tuser, cpu_tdata},
                          {2'b0, 1'b1, pu_b});
            if (chdr_tvalid && chdr_tready) begin
                n_chdr_words++;
                if (exp_chdr.size() == 0) begin
                    check_val("chdr_unexpected", 72'd1, 72'd0);
                end else begin
                    mon_e = exp_chdr.pop_front();
                    check_val("chdr_beat", {3'b0, chdr_tlast, chdr_tuser, chdr_tdata},
                              {3'b0, mon_e});
                end
            end
            if (cpu_tvalid && cpu_tready) begin
                n_cpu_words++;
                if (exp_cpu.size() == 0) begin
                    check_val("cpu_unexpected", 72'd1, 72'd0);
                end else begin
                    mon_e = exp_cpu.pop_front();
                    check_val("cpu_beat", {3'b0, cpu_tlast, cpu_tuser, cpu_tdata},
                              {3'b0, mon_e});
                end
            end
            pc_v = chdr_tvalid;
            pc_r = chdr_tready;
            pc_b = {chdr_tlast, chdr_tuser, chdr_tdata};
            pu_v = cpu_tvalid;
            pu_r = cpu_tready;
            pu_b = {cpu_tlast, cpu_tuser, cpu_tdata};
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge bus_clk);
        #1;
        check_val("rst_s_tready", {71'b0, s_axis_tready}, 72'd0);
        check_val("rst_valids", {70'b0, chdr_tvalid, cpu_tvalid}, 72'd0);
        check_val("rst_drop_count", 72'(drop_count), 72'd0);
        bus_rst_n = 1'b1;
        @(posedge bus_clk);
        #1;
        check_val("idle_s_tready", {71'b0, s_axis_tready}, 72'd1);

        // CHDR hit, 10 words: payload words 6..9 to the crossbar.
        clear_counts();
        run_frame(KChdr, 10, 4'd3, 1'b0);
        wait_drain();
        check_val("t1_chdr_words", 72'(n_chdr_words), 72'd4);
        check_val("t1_cpu_words", 72'(n_cpu_words), 72'd0);
        check_val("t1_drops", 72'(drop_count), 72'd0);

        // ARP broadcast, 8 words: whole frame to the CPU.
        clear_counts();
        run_frame(KBcast, 8, 4'd5, 1'b0);
        wait_drain();
        check_val("t2_cpu_words", 72'(n_cpu_words), 72'd8);
        check_val("t2_chdr_words", 72'(n_chdr_words), 72'd0);

        // Foreign MAC dropped, CHDR hit straight behind it.
        clear_counts();
        run_frame(KForeign, 12, 4'd0, 1'b0);
        run_frame(KChdr, 9, 4'd1, 1'b0);
        wait_drain();
        check_val("t3_chdr_words", 72'(n_chdr_words), 72'd3);
        check_val("t3_cpu_words", 72'(n_cpu_words), 72'd0);
        check_val("t3_drops", 72'(drop_count), 72'd1);

        // 4-word runt to my MAC, then a payload-less CHDR frame.
        clear_counts();
        run_frame(KChdr, 4, 4'd4, 1'b0);
        run_frame(KChdr, 6, 4'd2, 1'b0);
        wait_drain();
        check_val("t4_cpu_words", 72'(n_cpu_words), 72'd4);
        check_val("t4_chdr_words", 72'(n_chdr_words), 72'd0);
        check_val("t4_drops", 72'(drop_count), 72'd2);

        // Corrupted IP checksum on an otherwise valid CHDR frame.
        clear_counts();
        run_frame(KChdr, 8, 4'd0, 1'b1);
        wait_drain();
`ifdef ETH_RX_DISPATCH_IPCSUM_EN
        check_val("t5_cpu_words", 72'(n_cpu_words), 72'd8);
        check_val("t5_chdr_words", 72'(n_chdr_words), 72'd0);
`else
        check_val("t5_cpu_words", 72'(n_cpu_words), 72'd0);
        check_val("t5_chdr_words", 72'(n_chdr_words), 72'd2);
`endif

        // Async reset while streaming CHDR payload.
        clear_counts();
        build_frame(KChdr, 12, 4'd0, 1'b0);
        expect_frame();
        drive_frame(9);
        s_axis_tdata  = fword(9);
        s_axis_tvalid = 1'b1;
        #1;
        check_val("t6_pre_rst_valid", {71'b0, chdr_tvalid}, 72'd1);
        bus_rst_n = 1'b0;
        #1;
        check_val("t6_rst_chdr_valid", {71'b0, chdr_tvalid}, 72'd0);
        check_val("t6_rst_cpu_valid", {71'b0, cpu_tvalid}, 72'd0);
        check_val("t6_rst_s_tready", {71'b0, s_axis_tready}, 72'd0);
        check_val("t6_rst_drops", 72'(drop_count), 72'd0);
        check_val("t6_chdr_before", 72'(n_chdr_words), 72'd3);
        s_axis_tvalid = 1'b0;
        exp_chdr.delete();
        exp_cpu.delete();
        exp_drops = '0;
        repeat (3) @(posedge bus_clk);
        #1;
        bus_rst_n = 1'b1;
        @(posedge bus_clk);
        #1;
        clear_counts();
        run_frame(KChdr, 8, 4'd6, 1'b0);
        wait_drain();
        check_val("t6_chdr_after", 72'(n_chdr_words), 72'd2);
        check_val("t6_drops_after", 72'(drop_count), 72'd0);

        // Mixed traffic with random gaps and back-pressure.
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            int nw;
            nw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 5))
                                             : int'($urandom_range(6, 14));
            run_frame(kind_e'($urandom_range(0, 3)), nw, 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 7) == 0));
        end
        wait_drain();
        check_val("rand_drops", 72'(drop_count), 72'(exp_drops));
        rand_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
